// File: rtl/polyeta_pack_stream_if.sv
// Stream bundle for the eta-polynomial packer: coefficient input and packed-word output.
// The master modport drives coefficients and consumes words; the slave is the packer.
interface polyeta_pack_stream_if #(
  parameter int unsigned OUT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_coeff;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/polyeta_pack_stream.sv
// Streaming eta-polynomial packer: maps each coefficient c to (eta - c) on 3 or 4 bits,
// packs the values LSB-first and emits OUT_W-bit words with frame last/done signalling.
module polyeta_pack_stream #(
  parameter int unsigned N     = 256,
  parameter int unsigned OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   eta4_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  polyeta_pack_stream_if.slave   bus_if
);

  localparam int unsigned BufW   = OUT_W + 4;
  localparam int unsigned FillW  = $clog2(OUT_W + 4);
  localparam int unsigned CntW   = $clog2(N + 1);
  localparam int unsigned WordW  = $clog2(N * 4 / OUT_W + 1);
  localparam int unsigned Words4 = N * 4 / OUT_W;
  localparam int unsigned Words3 = N * 3 / OUT_W;

  localparam logic [FillW-1:0] OutWF     = FillW'(OUT_W);
  localparam logic [CntW-1:0]  LastCoeff = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic               eta4_q, eta4_d;
  logic               err_q, err_d;
  logic [BufW-1:0]    buf_q, buf_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CntW-1:0]    coeff_cnt_q, coeff_cnt_d;
  logic [WordW-1:0]   word_cnt_q, word_cnt_d;

  logic               in_ready, out_valid, push, pop, last_word, range_bad;
  logic [3:0]         v4, v;
  logic [FillW-1:0]   bits_per_coeff;
  logic [WordW-1:0]   words_m1;
  logic signed [31:0] coeff_s;

  // Only the low bits of (eta - c) survive truncation, so a 4-bit subtract suffices.
  assign coeff_s        = $signed(bus_if.in_coeff);
  assign v4             = (eta4_q ? 4'd4 : 4'd2) - bus_if.in_coeff[3:0];
  assign v              = eta4_q ? v4 : {1'b0, v4[2:0]};
  assign range_bad      = eta4_q ? (coeff_s < -32'sd4 || coeff_s > 32'sd4)
                                 : (coeff_s < -32'sd2 || coeff_s > 32'sd2);
  assign bits_per_coeff = eta4_q ? FillW'(4) : FillW'(3);
  assign words_m1       = eta4_q ? WordW'(Words4 - 1) : WordW'(Words3 - 1);

  assign in_ready  = (state_q == StLoad) && (fill_q < OutWF);
  assign out_valid = (fill_q >= OutWF);
  assign push      = in_ready && bus_if.in_valid;
  assign pop       = out_valid && bus_if.out_ready;
  assign last_word = (word_cnt_q == words_m1);

  always_comb begin
    state_d     = state_q;
    eta4_d      = eta4_q;
    err_d       = err_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    coeff_cnt_d = coeff_cnt_q;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StLoad;
          eta4_d      = eta4_i;
          err_d       = 1'b0;
          buf_d       = '0;
          fill_d      = '0;
          coeff_cnt_d = '0;
          word_cnt_d  = '0;
        end
      end
      StLoad: begin
        if (push) begin
          buf_d       = buf_q | (BufW'(v) << fill_q);
          fill_d      = fill_q + bits_per_coeff;
          coeff_cnt_d = coeff_cnt_q + CntW'(1);
          err_d       = err_q | range_bad;
          if (coeff_cnt_q == LastCoeff) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && last_word) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Push and pop are mutually exclusive because in_ready requires fill < OUT_W.
    if (pop) begin
      buf_d      = buf_q >> OUT_W;
      fill_d     = fill_q - OutWF;
      word_cnt_d = word_cnt_q + WordW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      eta4_q      <= 1'b0;
      err_q       <= 1'b0;
      buf_q       <= '0;
      fill_q      <= '0;
      coeff_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      eta4_q      <= eta4_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      coeff_cnt_q <= coeff_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign busy_o           = (state_q == StLoad) || (state_q == StDrain);
  assign done_o           = (state_q == StDone);
  assign err_o            = err_q;
  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid;
  assign bus_if.out_data  = buf_q[OUT_W-1:0];
  assign bus_if.out_last  = out_valid && last_word;

endmodule

// File: tb/tb_polyeta_pack_stream.sv
// Directed bench for polyeta_pack_stream (N=256, OUT_W=8) with hand-computed byte streams.
module tb_polyeta_pack_stream;
  localparam int N     = 256;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic eta4 = 1'b0;
  logic busy, done, err;

  polyeta_pack_stream_if #(.OUT_W(OUT_W)) bus ();

  polyeta_pack_stream #(.N(N), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .eta4_i  (eta4),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .bus_if  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int coeffs [N];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int last_idx [$];
  int neg_idx = 0;
  int last_hs_idx = 0;
  int done_idx = 0;
  int done_pulses = 0;

  // Observe handshakes on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk) begin
    neg_idx++;
    if (bus.out_valid && bus.out_ready) begin
      if (bus.out_last) last_idx.push_back(got.size());
      got.push_back(bus.out_data);
      last_hs_idx = neg_idx;
    end
    if (done) begin
      done_pulses++;
      done_idx = neg_idx;
    end
  end

  function automatic int count_bad();
    int b = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) b++;
    return b;
  endfunction

  task automatic clear_mon();
    got.delete();
    last_idx.delete();
    done_pulses = 0;
  endtask

  task automatic start_frame(input logic m);
    @(posedge clk); #1;
    eta4  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      logic acc;
      g = 0;
      bus.in_valid = 1'b1;
      bus.in_coeff = coeffs[i];
      do begin
        acc = bus.in_ready;
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 1000);
      if (!acc) begin
        tests++; fails++;
        $display("FAIL feed_timeout: coeff %0d not accepted, in_ready=%0b required 1", i, acc);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (done_pulses == 0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (done_pulses !== 1) begin
      fails++;
      $display("FAIL %s_done_pulses: got %0d required 1", name, done_pulses);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({busy, done, err, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0",
               {busy, done, err, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, err, bus.in_ready, bus.out_valid} !== 5'b0) begin
      fails++;
      $display("FAIL idle_outputs: got %b required 0",
               {busy, done, err, bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_zeros_eta4();
    int nb;
    for (int i = 0; i < N; i++) coeffs[i] = 0;
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(8'h44);
    clear_mon();
    start_frame(1'b1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL zeros_busy: got %b required 1", busy); end
    feed(N);
    wait_done("zeros");
    tests++;
    if (got.size() !== 128) begin
      fails++; $display("FAIL zeros_len: got %0d required 128", got.size());
    end
    nb = count_bad();
    tests++;
    if (nb !== 0) begin fails++; $display("FAIL zeros_data: %0d bad bytes, required 0", nb); end
    tests++;
    if (last_idx.size() !== 1 || last_idx[0] !== 127) begin
      fails++;
      $display("FAIL zeros_last: %0d last flags, first at %0d, required one at 127",
               last_idx.size(), (last_idx.size() > 0) ? last_idx[0] : -1);
    end
    tests++;
    if (done_idx !== last_hs_idx + 1) begin
      fails++;
      $display("FAIL zeros_done_timing: done at %0d required %0d", done_idx, last_hs_idx + 1);
    end
    tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL zeros_end_flags: busy=%b err=%b required 0 0", busy, err);
    end
  endtask

  task automatic test_alt_eta4();
    int nb;
    for (int i = 0; i < N; i++) coeffs[i] = (i % 2 == 0) ? 4 : -4;
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(8'h80);
    clear_mon();
    start_frame(1'b1);
    feed(N);
    wait_done("alt4");
    nb = count_bad();
    tests++;
    if (got.size() !== 128 || nb !== 0) begin
      fails++; $display("FAIL alt4_stream: len %0d bad %0d required 128 0", got.size(), nb);
    end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL alt4_err: got %b required 0", err); end
  endtask

  task automatic test_alt_eta2();
    int nb;
    for (int i = 0; i < N; i++) coeffs[i] = (i % 2 == 0) ? 2 : -2;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'h20); exp_q.push_back(8'h08); exp_q.push_back(8'h82);
    end
    clear_mon();
    start_frame(1'b0);
    feed(N);
    wait_done("alt2");
    nb = count_bad();
    tests++;
    if (got.size() !== 96 || nb !== 0) begin
      fails++; $display("FAIL alt2_stream: len %0d bad %0d required 96 0", got.size(), nb);
    end
    tests++;
    if (last_idx.size() !== 1 || last_idx[0] !== 95 || err !== 1'b0) begin
      fails++;
      $display("FAIL alt2_last_err: %0d last flags err=%b required one at 95, err 0",
               last_idx.size(), err);
    end
  endtask

  task automatic test_range_err();
    int nb;
    for (int i = 0; i < N; i++) coeffs[i] = 0;
    coeffs[0] = 5;
    exp_q.delete();
    exp_q.push_back(8'h4F);
    for (int i = 1; i < 128; i++) exp_q.push_back(8'h44);
    clear_mon();
    start_frame(1'b1);
    feed(N);
    wait_done("range");
    nb = count_bad();
    tests++;
    if (got.size() !== 128 || nb !== 0) begin
      fails++; $display("FAIL range_stream: len %0d bad %0d required 128 0", got.size(), nb);
    end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL range_err_set: got %b required 1", err); end
    coeffs[0] = 0;
    clear_mon();
    start_frame(1'b1);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL range_err_clear: got %b required 0", err); end
    feed(N);
    wait_done("range_clean");
  endtask

  task automatic test_backpressure();
    int nb;
    logic stall_ok;
    logic [7:0] held;
    for (int i = 0; i < N; i++) coeffs[i] = (i % 2 == 0) ? 2 : -2;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(8'h20); exp_q.push_back(8'h08); exp_q.push_back(8'h82);
    end
    clear_mon();
    stall_ok = 1'b1;
    start_frame(1'b0);
    fork
      feed(N);
      begin
        repeat (40) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 held = bus.out_data;
        repeat (7) begin
          if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== held)
            stall_ok = 1'b0;
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_done("bp");
    tests++;
    if (stall_ok !== 1'b1) begin
      fails++; $display("FAIL bp_stall_hold: got %b required 1", stall_ok);
    end
    nb = count_bad();
    tests++;
    if (got.size() !== 96 || nb !== 0) begin
      fails++; $display("FAIL bp_stream: len %0d bad %0d required 96 0", got.size(), nb);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nb;
    for (int i = 0; i < N; i++) coeffs[i] = (i % 2 == 0) ? 2 : -2;
    coeffs[0] = 5;
    clear_mon();
    start_frame(1'b0);
    feed(50);
    rst_n = 1'b0;
    #3;
    tests++;
    if ({busy, done, err, bus.in_ready, bus.out_valid} !== 5'b0) begin
      fails++;
      $display("FAIL midrst_outputs: got %b required 0",
               {busy, done, err, bus.in_ready, bus.out_valid});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < N; i++) coeffs[i] = 0;
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(8'h44);
    clear_mon();
    start_frame(1'b1);
    feed(N);
    wait_done("midrst");
    nb = count_bad();
    tests++;
    if (got.size() !== 128 || nb !== 0 || err !== 1'b0) begin
      fails++;
      $display("FAIL midrst_stream: len %0d bad %0d err %b required 128 0 0",
               got.size(), nb, err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_coeff  = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_zeros_eta4();
    test_alt_eta4();
    test_alt_eta2();
    test_range_err();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
